// File: rtl/instr_parse.sv
// -----------------------------------------------------------------------------
// instr_parse
//   Registered LEGv8 instruction field decoder for the decode stage of the
//   nonpipelined core. It splits a 32-bit instruction into raw register and
//   opcode fields, works out the format class, and builds the extended
//   immediate for that format. All outputs are registered one cycle after
//   capture.
//
// Ports
//   clk          in   1          system clock, rising edge
//   rst          in   1          asynchronous active-high reset
//   instruction  in   INSTR_LEN  raw instruction word
//   in_valid     in   1          capture instruction on this edge when high
//   opcode       out  11         instruction[31:21]
//   rm           out  5          instruction[20:16]
//   rn           out  5          instruction[9:5]
//   rd           out  5          instruction[4:0] (Rt for D/CB formats)
//   address      out  9          instruction[20:12], raw D-format offset
//   shamt        out  6          instruction[15:10]
//   fmt          out  3          0=R 1=I 2=D 3=B 4=CB 5=IW
//   imm          out  IMM_W      extended immediate for the decoded format
//   out_valid    out  1          outputs hold a newly captured instruction
// -----------------------------------------------------------------------------
module instr_parse #(
   parameter int INSTR_LEN = 32,
   parameter int IMM_W     = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [INSTR_LEN-1:0] instruction,
   input  logic                 in_valid,
   output logic [10:0]          opcode,
   output logic [4:0]           rm,
   output logic [4:0]           rn,
   output logic [4:0]           rd,
   output logic [8:0]           address,
   output logic [5:0]           shamt,
   output logic [2:0]           fmt,
   output logic [IMM_W-1:0]     imm,
   output logic                 out_valid
);

   localparam logic [2:0] FMT_R  = 3'd0;
   localparam logic [2:0] FMT_I  = 3'd1;
   localparam logic [2:0] FMT_D  = 3'd2;
   localparam logic [2:0] FMT_B  = 3'd3;
   localparam logic [2:0] FMT_CB = 3'd4;
   localparam logic [2:0] FMT_IW = 3'd5;

   logic [10:0]      op_s;
   logic             is_i_s;
   logic             is_d_s;
   logic [2:0]       fmt_d;
   logic [IMM_W-1:0] imm_d;

   logic [10:0]      opcode_q;
   logic [4:0]       rm_q;
   logic [4:0]       rn_q;
   logic [4:0]       rd_q;
   logic [8:0]       address_q;
   logic [5:0]       shamt_q;
   logic [2:0]       fmt_q;
   logic [IMM_W-1:0] imm_q;
   logic             out_valid_q;

   assign op_s = instruction[31:21];

   // Opcode-set membership for the I and D formats.
   always_comb begin
      is_i_s = 1'b0;
      is_d_s = 1'b0;
      case (op_s[10:1])
         10'b1001000100, 10'b1011000100, 10'b1101000100, 10'b1111000100,
         10'b1001001000, 10'b1111001000, 10'b1011001000, 10'b1101001000:
            is_i_s = 1'b1;
         default:
            is_i_s = 1'b0;
      endcase
      case (op_s)
         11'b11111000010, 11'b11111000000, 11'b10111000100, 11'b10111000000,
         11'b01111000010, 11'b01111000000, 11'b00111000010, 11'b00111000000,
         11'b11001000010, 11'b11001000000:
            is_d_s = 1'b1;
         default:
            is_d_s = 1'b0;
      endcase
   end

   // Format classification; the narrowest opcode prefixes are tested first.
   always_comb begin
      fmt_d = FMT_R;
      if (op_s[10:5] == 6'b000101 || op_s[10:5] == 6'b100101) begin
         fmt_d = FMT_B;
      end else if (op_s[10:3] == 8'b10110100 || op_s[10:3] == 8'b10110101 ||
                   op_s[10:3] == 8'b01010100) begin
         fmt_d = FMT_CB;
      end else if (op_s[10:2] == 9'b110100101 || op_s[10:2] == 9'b111100101) begin
         fmt_d = FMT_IW;
      end else if (is_i_s) begin
         fmt_d = FMT_I;
      end else if (is_d_s) begin
         fmt_d = FMT_D;
      end else begin
         fmt_d = FMT_R;
      end
   end

   // Immediate extension per format. Branch offsets stay unscaled; the
   // wide-move payload is placed at the halfword picked by instruction[22:21].
   always_comb begin
      imm_d = {IMM_W{1'b0}};
      case (fmt_d)
         FMT_I:   imm_d = {{(IMM_W-12){1'b0}}, instruction[21:10]};
         FMT_D:   imm_d = {{(IMM_W-9){instruction[20]}}, instruction[20:12]};
         FMT_B:   imm_d = {{(IMM_W-26){instruction[25]}}, instruction[25:0]};
         FMT_CB:  imm_d = {{(IMM_W-19){instruction[23]}}, instruction[23:5]};
         FMT_IW:  imm_d = {{(IMM_W-16){1'b0}}, instruction[20:5]}
                          << {instruction[22:21], 4'b0000};
         default: imm_d = {{(IMM_W-6){1'b0}}, instruction[15:10]};
      endcase
   end

   // Output registers: load on in_valid, otherwise hold fields and drop valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opcode_q    <= 11'd0;
         rm_q        <= 5'd0;
         rn_q        <= 5'd0;
         rd_q        <= 5'd0;
         address_q   <= 9'd0;
         shamt_q     <= 6'd0;
         fmt_q       <= FMT_R;
         imm_q       <= {IMM_W{1'b0}};
         out_valid_q <= 1'b0;
      end else if (in_valid) begin
         opcode_q    <= op_s;
         rm_q        <= instruction[20:16];
         rn_q        <= instruction[9:5];
         rd_q        <= instruction[4:0];
         address_q   <= instruction[20:12];
         shamt_q     <= instruction[15:10];
         fmt_q       <= fmt_d;
         imm_q       <= imm_d;
         out_valid_q <= 1'b1;
      end else begin
         out_valid_q <= 1'b0;
      end
   end

   assign opcode    = opcode_q;
   assign rm        = rm_q;
   assign rn        = rn_q;
   assign rd        = rd_q;
   assign address   = address_q;
   assign shamt     = shamt_q;
   assign fmt       = fmt_q;
   assign imm       = imm_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_instr_parse.sv
// -----------------------------------------------------------------------------
// tb_instr_parse
//   Directed-vector bench for instr_parse with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_instr_parse;

   logic        clk;
   logic        rst;
   logic [31:0] instruction;
   logic        in_valid;
   logic [10:0] opcode;
   logic [4:0]  rm;
   logic [4:0]  rn;
   logic [4:0]  rd;
   logic [8:0]  address;
   logic [5:0]  shamt;
   logic [2:0]  fmt;
   logic [63:0] imm;
   logic        out_valid;

   int chk_cnt;
   int err_cnt;

   instr_parse #(.INSTR_LEN(32), .IMM_W(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .instruction (instruction),
      .in_valid    (in_valid),
      .opcode      (opcode),
      .rm          (rm),
      .rn          (rn),
      .rd          (rd),
      .address     (address),
      .shamt       (shamt),
      .fmt         (fmt),
      .imm         (imm),
      .out_valid   (out_valid)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt = chk_cnt + 1;
      if (obs !== exp) begin
         err_cnt = err_cnt + 1;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one instruction at the falling edge, then sample 1 ns after capture.
   task automatic apply(input logic [31:0] ins, input logic vld);
      @(negedge clk);
      instruction = ins;
      in_valid    = vld;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, ".opcode"},    64'(opcode),    64'd0);
      check_eq({tag, ".rm"},        64'(rm),        64'd0);
      check_eq({tag, ".rn"},        64'(rn),        64'd0);
      check_eq({tag, ".rd"},        64'(rd),        64'd0);
      check_eq({tag, ".address"},   64'(address),   64'd0);
      check_eq({tag, ".shamt"},     64'(shamt),     64'd0);
      check_eq({tag, ".fmt"},       64'(fmt),       64'd0);
      check_eq({tag, ".imm"},       imm,            64'd0);
      check_eq({tag, ".out_valid"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      chk_cnt     = 0;
      err_cnt     = 0;
      rst         = 1'b1;
      in_valid    = 1'b1;
      instruction = 32'hF84F0149;   // LDUR X9,[X10,#240]

      // Reset held across edges with a valid instruction present
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("rst_hold");

      // Release reset; the next edge loads LDUR
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("ldur.opcode",  64'(opcode),    64'h7C2);
      check_eq("ldur.rm",      64'(rm),        64'd15);
      check_eq("ldur.rn",      64'(rn),        64'd10);
      check_eq("ldur.rd",      64'(rd),        64'd9);
      check_eq("ldur.address", 64'(address),   64'd240);
      check_eq("ldur.shamt",   64'(shamt),     64'd0);
      check_eq("ldur.fmt",     64'(fmt),       64'd2);
      check_eq("ldur.imm",     imm,            64'd240);
      check_eq("ldur.valid",   64'(out_valid), 64'd1);

      // ADD X10,X21,X9 (R format)
      apply(32'h8B0902AA, 1'b1);
      check_eq("add.opcode",  64'(opcode),  64'h458);
      check_eq("add.rm",      64'(rm),      64'd9);
      check_eq("add.rn",      64'(rn),      64'd21);
      check_eq("add.rd",      64'(rd),      64'd10);
      check_eq("add.address", 64'(address), 64'h090);
      check_eq("add.shamt",   64'(shamt),   64'd0);
      check_eq("add.fmt",     64'(fmt),     64'd0);
      check_eq("add.imm",     imm,          64'd0);

      // STUR X9,[X10,#240]
      apply(32'hF80F0149, 1'b1);
      check_eq("stur.opcode",  64'(opcode),  64'h7C0);
      check_eq("stur.rn",      64'(rn),      64'd10);
      check_eq("stur.rd",      64'(rd),      64'd9);
      check_eq("stur.address", 64'(address), 64'd240);
      check_eq("stur.fmt",     64'(fmt),     64'd2);
      check_eq("stur.imm",     imm,          64'd240);

      // STUR X9,[X10,#-8]: negative offset sign-extends
      apply(32'hF81F8149, 1'b1);
      check_eq("sturn.address", 64'(address), 64'h1F8);
      check_eq("sturn.rm",      64'(rm),      64'd31);
      check_eq("sturn.shamt",   64'(shamt),   64'd32);
      check_eq("sturn.fmt",     64'(fmt),     64'd2);
      check_eq("sturn.imm",     imm,          64'hFFFF_FFFF_FFFF_FFF8);

      // B #-1: 26-bit all-ones offset
      apply(32'h17FFFFFF, 1'b1);
      check_eq("b.opcode", 64'(opcode), 64'h0BF);
      check_eq("b.fmt",    64'(fmt),    64'd3);
      check_eq("b.imm",    imm,         64'hFFFF_FFFF_FFFF_FFFF);

      // CBZ X1,#4
      apply(32'hB4000081, 1'b1);
      check_eq("cbz.fmt", 64'(fmt), 64'd4);
      check_eq("cbz.imm", imm,      64'd4);
      check_eq("cbz.rd",  64'(rd),  64'd1);

      // MOVZ X0,#0x1234,LSL#16
      apply(32'hD2A24680, 1'b1);
      check_eq("movz.fmt", 64'(fmt), 64'd5);
      check_eq("movz.imm", imm,      64'h0000_0000_1234_0000);
      check_eq("movz.rd",  64'(rd),  64'd0);

      // ADDI X1,X2,#5
      apply(32'h91001441, 1'b1);
      check_eq("addi.fmt",   64'(fmt),       64'd1);
      check_eq("addi.imm",   imm,            64'd5);
      check_eq("addi.rn",    64'(rn),        64'd2);
      check_eq("addi.rd",    64'(rd),        64'd1);
      check_eq("addi.valid", 64'(out_valid), 64'd1);

      // in_valid low with a different instruction: fields hold, valid drops
      apply(32'h8B0902AA, 1'b0);
      check_eq("hold.opcode", 64'(opcode),    64'h488);
      check_eq("hold.fmt",    64'(fmt),       64'd1);
      check_eq("hold.imm",    imm,            64'd5);
      check_eq("hold.rn",     64'(rn),        64'd2);
      check_eq("hold.rd",     64'(rd),        64'd1);
      check_eq("hold.valid",  64'(out_valid), 64'd0);

      // Recapture ADDI, then assert reset mid-cycle: outputs clear before the next edge
      apply(32'h91001441, 1'b1);
      check_eq("recap.valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");

      // Release and confirm capture resumes
      @(negedge clk);
      rst = 1'b0;
      apply(32'hB4000081, 1'b1);
      check_eq("post.fmt",   64'(fmt),       64'd4);
      check_eq("post.imm",   imm,            64'd4);
      check_eq("post.valid", 64'(out_valid), 64'd1);

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/instr_parse.md
Name: instr_parse

Overview:
- Registered LEGv8 instruction field decoder in the decode stage of the nonpipelined core.
- Splits a 32-bit instruction into register specifiers, opcode, D-format address, shift amount, format class and sign/zero-extended immediate.
- All outputs are registered, one cycle after capture.

Parameters:
- INSTR_LEN, 32, instruction width (codebase `INSTR_LEN); only 32 is supported.
- IMM_W, 64, width of extended immediate output.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- instruction  in  INSTR_LEN  raw instruction word.
- in_valid  in  1  instruction is captured on this rising edge when high.
- opcode  out  11  instruction[31:21].
- rm  out  5  instruction[20:16].
- rn  out  5  instruction[9:5].
- rd  out  5  instruction[4:0]; this is Rt for D/CB formats.
- address  out  9  instruction[20:12], the D-format offset, raw.
- shamt  out  6  instruction[15:10].
- fmt  out  3  format class: 0=R, 1=I, 2=D, 3=B, 4=CB, 5=IW.
- imm  out  IMM_W  extended immediate for the decoded format.
- out_valid  out  1  outputs hold a newly captured instruction.

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0; fmt=0, out_valid=0.
  - Outputs are held at 0 while rst is high.
  - Assertion mid-operation clears outputs immediately, without waiting for clk.
- Capture:
  - On a rising clk with in_valid=1, all fields are computed from the instruction and registered; out_valid<=1.
  - On a rising clk with in_valid=0, fields hold their previous values; out_valid<=0.
  - Latency is exactly 1 cycle. No backpressure.
- Raw fields (opcode, rm, rn, rd, address, shamt):
  - Always extracted at the fixed bit positions above, regardless of format.
- fmt classification, first match wins, on op=instruction[31:21]:
  - B: op[10:5] = 000101 (B) or 100101 (BL).
  - CB: op[10:3] = 10110100 (CBZ), 10110101 (CBNZ) or 01010100 (B.cond).
  - IW: op[10:2] = 110100101 (MOVZ) or 111100101 (MOVK).
  - I: op[10:1] in {1001000100 ADDI, 1011000100 ADDIS, 1101000100 SUBI, 1111000100 SUBIS, 1001001000 ANDI, 1111001000 ANDIS, 1011001000 ORRI, 1101001000 EORI}.
  - D: op in {11111000010 LDUR, 11111000000 STUR, 10111000100 LDURSW, 10111000000 STURW, 01111000010 LDURH, 01111000000 STURH, 00111000010 LDURB, 00111000000 STURB, 11001000010 LDXR, 11001000000 STXR}.
  - R: everything else, including unrecognised opcodes. No illegal-instruction flag.
- imm by format:
  - R: zero-extended shamt.
  - I: zero-extended instruction[21:10].
  - D: sign-extended instruction[20:12].
  - B: sign-extended instruction[25:0].
  - CB: sign-extended instruction[23:5].
  - IW: zero-extended instruction[20:5] shifted left by 16*instruction[22:21] (0/16/32/48); bits above IMM_W are discarded.
- Sign extension replicates the field MSB to bit IMM_W-1. The immediate is not scaled by 4; branch offset scaling happens downstream.
- rst wins over a simultaneous clk edge.

Test Plan:
- Reset: assert rst, then drive LDUR X9,[X10,#240] with in_valid=1 -> all outputs 0, out_valid=0. Release rst -> next edge loads the instruction.
- LDUR X9,[X10,#240] = 0xF84F0149 -> opcode=0x7C2, rm=15, rn=10, rd=9, address=240, fmt=2, imm=240, out_valid=1 one cycle after capture.
- ADD X10,X21,X9 = 0x8B0902AA -> opcode=0x458, rm=9, rn=21, rd=10, address=0x090, shamt=0, fmt=0, imm=0.
- STUR X9,[X10,#240] = 0xF80F0149 -> opcode=0x7C0, rn=10, rd=9, address=240, fmt=2. Also STUR with offset -8 (address field 0x1F8) -> imm=0xFFFF_FFFF_FFFF_FFF8.
- B #-1 = 0x17FFFFFF -> fmt=3, imm=all ones. CBZ X1,#4 = 0xB4000081 -> fmt=4, imm=4, rd=1. MOVZ X0,#0x1234,LSL#16 = 0xD2A24680 -> fmt=5, imm=0x12340000.
- Hold/valid: capture ADDI X1,X2,#5 (0x91001441) -> fmt=1, imm=5. Then in_valid=0 with a new instruction -> fields unchanged, out_valid=0. Then assert rst asynchronously mid-cycle -> outputs 0 before the next edge.
